// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator: decodes the immediate of an incoming instruction,
// computes pc + imm, and queues the results in a 2-entry buffer toward execute.
module imm_gen_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RV64_OPS = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam int unsigned CNT_W   = 2;
    localparam bit          RV64_EN = (XLEN == 64) && (RV64_OPS == 1);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [31:0]      imm32;
    logic [XLEN-1:0]  imm_ext;
    fmt_e             fmt_sel;
    logic             illegal_sel;
    entry_t           dec;

    logic [CNT_W-1:0] count_q, count_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             push, pop;

    // Opcode decode into a 32-bit immediate, then sign-extend to XLEN
    always_comb begin
        imm32       = '0;
        fmt_sel     = FMT_NONE;
        illegal_sel = 1'b0;
        case (in_ir[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                imm32   = {{20{in_ir[31]}}, in_ir[31:20]};
                fmt_sel = FMT_I;
            end
            7'b0011011: begin
                if (RV64_EN) begin
                    imm32   = {{20{in_ir[31]}}, in_ir[31:20]};
                    fmt_sel = FMT_I;
                end else begin
                    illegal_sel = 1'b1;
                end
            end
            7'b0100011: begin
                imm32   = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
                fmt_sel = FMT_S;
            end
            7'b1100011: begin
                imm32   = {{20{in_ir[31]}}, in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
                fmt_sel = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                imm32   = {in_ir[31:12], 12'b0};
                fmt_sel = FMT_U;
            end
            7'b1101111: begin
                imm32   = {{12{in_ir[31]}}, in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
                fmt_sel = FMT_J;
            end
            7'b0110011: fmt_sel = FMT_NONE;
            default:    illegal_sel = 1'b1;
        endcase

        imm_ext        = {XLEN{imm32[31]}};
        imm_ext[31:0]  = imm32;

        dec.imm     = imm_ext;
        dec.target  = in_pc + imm_ext;
        dec.pc      = in_pc;
        dec.fmt     = fmt_sel;
        dec.illegal = illegal_sel;
    end

    // Two-entry buffer; head_q always drives out_*, so a push into an empty or
    // simultaneously-popped buffer lands straight in head.
    always_comb begin
        push        = in_valid & in_ready_q & ~flush;
        pop         = out_valid_q & out_ready;
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case (count_q)
                CNT_W'(0): begin
                    if (push) begin
                        head_d  = dec;
                        count_d = CNT_W'(1);
                    end
                end
                CNT_W'(1): begin
                    if (push && pop) begin
                        head_d = dec;
                    end else if (push) begin
                        tail_d  = dec;
                        count_d = CNT_W'(2);
                    end else if (pop) begin
                        count_d = CNT_W'(0);
                    end
                end
                CNT_W'(2): begin
                    if (pop) begin
                        head_d  = tail_q;
                        count_d = CNT_W'(1);
                    end
                end
                default: count_d = '0;
            endcase
        end
        in_ready_d  = (count_d != CNT_W'(2));
        out_valid_d = (count_d != CNT_W'(0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = head_q.imm;
    assign out_target  = head_q.target;
    assign out_pc      = head_q.pc;
    assign out_fmt     = head_q.fmt;
    assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV32 and an RV64 instance share stimulus and are
// compared against a queue-based reference model with arithmetic immediate decode.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_ir;
    logic [63:0] pc64;
    logic [31:0] pc32;
    logic        out_ready;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32, tgt32, opc32;
    logic [2:0]  fmt32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64, tgt64, opc64;
    logic [2:0]  fmt64;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [63:0] pc;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;
    assign pc32 = pc64[31:0];

    imm_gen_pipe #(.XLEN(32), .RV64_OPS(0)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_ir(in_ir), .in_pc(pc32),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
        .out_target(tgt32), .out_pc(opc32), .out_fmt(fmt32), .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .RV64_OPS(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_ir(in_ir), .in_pc(pc64),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
        .out_target(tgt64), .out_pc(opc64), .out_fmt(fmt64), .out_illegal(ill64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference decode written as field arithmetic on signed integers
    function automatic exp_t ref_entry(input logic [31:0] ir, input logic [63:0] pc, input bit is64);
        exp_t        e;
        longint      v;
        logic [63:0] mask;
        v     = 0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        case (ir[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: begin
                v = longint'(ir[31:20]); if (v >= 2048) v -= 4096; e.fmt = 3'd1;
            end
            7'h1B: begin
                if (is64) begin
                    v = longint'(ir[31:20]); if (v >= 2048) v -= 4096; e.fmt = 3'd1;
                end else e.ill = 1'b1;
            end
            7'h23: begin
                v = longint'(ir[31:25]) * 32 + longint'(ir[11:7]);
                if (v >= 2048) v -= 4096; e.fmt = 3'd2;
            end
            7'h63: begin
                v = longint'(ir[31]) * 4096 + longint'(ir[7]) * 2048
                  + longint'(ir[30:25]) * 32 + longint'(ir[11:8]) * 2;
                if (v >= 4096) v -= 8192; e.fmt = 3'd3;
            end
            7'h37, 7'h17: begin
                v = longint'(ir[31:12]) * 4096;
                if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000; e.fmt = 3'd4;
            end
            7'h6F: begin
                v = longint'(ir[31]) * 1048576 + longint'(ir[19:12]) * 4096
                  + longint'(ir[20]) * 2048 + longint'(ir[30:21]) * 2;
                if (v >= 1048576) v -= 2097152; e.fmt = 3'd5;
            end
            7'h33: e.fmt = 3'd0;
            default: e.ill = 1'b1;
        endcase
        mask  = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        e.imm = 64'(v) & mask;
        e.pc  = pc & mask;
        e.tgt = (pc + 64'(v)) & mask;
        return e;
    endfunction

    task automatic model_step(input bit v, input logic [31:0] ir, input logic [63:0] pc,
                              input bit ordy, input bit fl);
        bit push32, pop32, push64, pop64;
        push32 = v && (q32.size() < 2) && !fl;
        pop32  = (q32.size() > 0) && ordy;
        push64 = v && (q64.size() < 2) && !fl;
        pop64  = (q64.size() > 0) && ordy;
        if (fl) begin
            q32.delete();
            q64.delete();
        end else begin
            if (pop32) void'(q32.pop_front());
            if (push32) q32.push_back(ref_entry(ir, pc, 1'b0));
            if (pop64) void'(q64.pop_front());
            if (push64) q64.push_back(ref_entry(ir, pc, 1'b1));
        end
    endtask

    task automatic compare_all();
        chk("in_ready32", 64'(rdy32), 64'(q32.size() < 2));
        chk("out_valid32", 64'(vld32), 64'(q32.size() > 0));
        if (q32.size() > 0) begin
            chk("imm32", 64'(imm32), q32[0].imm);
            chk("target32", 64'(tgt32), q32[0].tgt);
            chk("pc32", 64'(opc32), q32[0].pc);
            chk("fmt32", 64'(fmt32), 64'(q32[0].fmt));
            chk("illegal32", 64'(ill32), 64'(q32[0].ill));
        end
        chk("in_ready64", 64'(rdy64), 64'(q64.size() < 2));
        chk("out_valid64", 64'(vld64), 64'(q64.size() > 0));
        if (q64.size() > 0) begin
            chk("imm64", imm64, q64[0].imm);
            chk("target64", tgt64, q64[0].tgt);
            chk("pc64", opc64, q64[0].pc);
            chk("fmt64", 64'(fmt64), 64'(q64[0].fmt));
            chk("illegal64", 64'(ill64), 64'(q64[0].ill));
        end
    endtask

    task automatic step(input bit v, input logic [31:0] ir, input logic [63:0] pc,
                        input bit ordy, input bit fl);
        in_valid  = v;
        in_ir     = ir;
        pc64      = pc;
        out_ready = ordy;
        flush     = fl;
        model_step(v, ir, pc, ordy, fl);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(vld32 | vld64), 64'd0);
        chk({tag, "_ready"}, 64'({rdy32, rdy64}), 64'd3);
        chk({tag, "_data32"}, 64'(imm32 | tgt32 | opc32 | 32'(fmt32) | 32'(ill32)), 64'd0);
        chk({tag, "_data64"}, imm64 | tgt64 | opc64 | 64'(fmt64) | 64'(ill64), 64'd0);
    endtask

    function automatic logic [31:0] pick_ir();
        logic [6:0]  ops [12];
        logic [31:0] r;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
        r = $urandom;
        if ($urandom_range(0, 7) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 11)]};
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ir = '0; pc64 = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed decode vectors, streamed with out_ready high
        step(1, 32'hFFF0_0093, 64'h0, 1, 0);
        chk("addi_imm", 64'(imm32), 64'hFFFF_FFFF);
        chk("addi_tgt", 64'(tgt32), 64'hFFFF_FFFF);
        chk("addi_fmt", 64'(fmt32), 64'd1);
        step(1, 32'hFE00_0EE3, 64'h100, 1, 0);
        chk("beq_imm", 64'(imm32), 64'hFFFF_FFFC);
        chk("beq_tgt", 64'(tgt32), 64'h0000_00FC);
        chk("beq_fmt", 64'(fmt32), 64'd3);
        step(1, 32'h0010_00EF, 64'h1000, 1, 0);
        chk("jal_imm", 64'(imm32), 64'h800);
        chk("jal_tgt", 64'(tgt32), 64'h1800);
        chk("jal_fmt", 64'(fmt32), 64'd5);
        step(1, 32'h8000_00B7, 64'h0, 1, 0);
        chk("lui64_neg", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("lui64_fmt", 64'(fmt64), 64'd4);
        step(1, 32'h1234_50B7, 64'h0, 1, 0);
        chk("lui64_pos", imm64, 64'h0000_0000_1234_5000);
        step(1, 32'h0010_009B, 64'h8, 1, 0);
        chk("addiw32_ill", 64'(ill32), 64'd1);
        chk("addiw64_fmt", 64'(fmt64), 64'd1);
        step(0, 32'h0, 64'h0, 1, 0);

        // Backpressure: third push refused until the buffer drains
        step(1, 32'h0000_0013, 64'h10, 0, 0);
        step(1, 32'h0000_0113, 64'h14, 0, 0);
        chk("bp_full", 64'(rdy32), 64'd0);
        step(1, 32'h0000_0213, 64'h18, 0, 0);
        chk("bp_hold_pc", 64'(opc32), 64'h10);
        step(1, 32'h0000_0213, 64'h18, 1, 0);
        chk("bp_second", 64'(opc32), 64'h14);
        step(1, 32'h0000_0213, 64'h18, 1, 0);
        chk("bp_third", 64'(opc32), 64'h18);
        step(0, 32'h0, 64'h0, 1, 0);

        // Unknown opcode still flows through in order
        step(1, 32'h0000_007F, 64'h40, 1, 0);
        chk("ill_flag", 64'(ill32), 64'd1);
        chk("ill_fmt", 64'(fmt32), 64'd0);
        chk("ill_imm", 64'(imm32), 64'd0);
        chk("ill_tgt", 64'(tgt32), 64'h40);

        // Flush with full buffer and a same-cycle push
        step(1, 32'h0000_0013, 64'h50, 0, 0);
        step(1, 32'h0000_0013, 64'h54, 0, 0);
        step(1, 32'h0000_0013, 64'h58, 0, 1);
        chk("flush_valid", 64'(vld32), 64'd0);
        chk("flush_ready", 64'(rdy32), 64'd1);

        // Asynchronous reset while full, checked before the next rising edge
        step(1, 32'h0000_0013, 64'h60, 0, 0);
        step(1, 32'h0000_0013, 64'h64, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        q32.delete();
        q64.delete();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), pick_ir(), {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
